wts_ram_arbiter: RTL and testbench

- Shares the single-port 512x8 wave-table RAM (`wts_ram`) between two requesters: the CPU bus interface and the wave-generator sample fetcher.
- Arbitrates one access per cycle and drives the RAM port from registers.
- Tracks in-flight reads through the RAM's fixed read latency and routes returned data back to the owner with a one-cycle ack.
- Sits between the bus decoder / tone engine and `wts_ram`.

---
 rtl/wts_ram_arb_pkg.sv | 15 +
 rtl/wts_ram_arbiter_if.sv | 33 +++
 rtl/wts_ram_arb_retire.sv | 38 +++
 rtl/wts_ram_arbiter.sv | 136 +++++++++++++
 tb/tb_wts_ram_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wts_ram_arb_pkg.sv
// Shared widths, owner tags and constants for the wave-table RAM arbiter.
package wts_ram_arb_pkg;

   localparam int WTS_RAM_AW = 9;
   localparam int WTS_RAM_DW = 8;

   localparam logic [WTS_RAM_DW-1:0] WTS_OOR_DATA = 8'hFF;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_WAV
   } owner_e;

endpackage

// File: rtl/wts_ram_arbiter_if.sv
// Requester and RAM-port signals of the wave-table RAM arbiter.
// The arbiter uses the slave view; the requesters/RAM side uses the master view.
interface wts_ram_arbiter_if;
   import wts_ram_arb_pkg::*;

   logic                  cpu_req;
   logic                  cpu_we;
   logic [WTS_RAM_AW-1:0] cpu_a;
   logic [WTS_RAM_DW-1:0] cpu_d;
   logic                  cpu_ack;
   logic [WTS_RAM_DW-1:0] cpu_q;

   logic                  wav_req;
   logic [WTS_RAM_AW-1:0] wav_a;
   logic                  wav_ack;
   logic [WTS_RAM_DW-1:0] wav_q;

   logic                  sram_we;
   logic [WTS_RAM_AW-1:0] sram_a;
   logic [WTS_RAM_DW-1:0] sram_d;
   logic [WTS_RAM_DW-1:0] sram_q;

   modport slave (
      input  cpu_req, cpu_we, cpu_a, cpu_d, wav_req, wav_a, sram_q,
      output cpu_ack, cpu_q, wav_ack, wav_q, sram_we, sram_a, sram_d
   );

   modport master (
      output cpu_req, cpu_we, cpu_a, cpu_d, wav_req, wav_a, sram_q,
      input  cpu_ack, cpu_q, wav_ack, wav_q, sram_we, sram_a, sram_d
   );

endinterface

// File: rtl/wts_ram_arb_retire.sv
// Owner-tag shift pipe: delays the tag of each issued read by STAGES cycles so
// that it emerges in the cycle the RAM returns that read's data.
module wts_ram_arb_retire
   import wts_ram_arb_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic   clk,
   input  logic   reset,
   input  owner_e tag_own,
   input  logic   tag_oor,
   output owner_e cap_own,
   output logic   cap_oor
);

   owner_e own_pipe [STAGES];
   logic   oor_pipe [STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            own_pipe[i] <= OWN_NONE;
            oor_pipe[i] <= 1'b0;
         end
      end else begin
         own_pipe[0] <= tag_own;
         oor_pipe[0] <= tag_oor;
         for (int i = 1; i < STAGES; i++) begin
            own_pipe[i] <= own_pipe[i-1];
            oor_pipe[i] <= oor_pipe[i-1];
         end
      end
   end

   assign cap_own = own_pipe[STAGES-1];
   assign cap_oor = oor_pipe[STAGES-1];

endmodule

// File: rtl/wts_ram_arbiter.sv
// Shares the single-port wave-table RAM between the CPU and the wave fetcher.
// Build option: define WTS_RAM_ARBITER_ROUND_ROBIN_EN for alternating tie-break on contention.
module wts_ram_arbiter
   import wts_ram_arb_pkg::*;
#(
   parameter int RAM_WORDS    = 384,
   parameter int READ_LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   wts_ram_arbiter_if.slave bus
);

   logic                  busy_cpu, busy_wav;
   logic                  cpu_elig, wav_elig, wav_first;
   owner_e                grant;
   logic [WTS_RAM_AW-1:0] grant_a;
   logic                  grant_we, grant_oor;

   logic                  sram_we_p0;
   logic [WTS_RAM_AW-1:0] sram_a_p0;
   logic [WTS_RAM_DW-1:0] sram_d_p0;
   owner_e                iss_own_p0;
   logic                  iss_wr_p0, iss_oor_p0;

   owner_e                tag_own, cap_own;
   logic                  cap_oor;
   logic                  cpu_ack_r, wav_ack_r;
   logic [WTS_RAM_DW-1:0] cpu_q_r, wav_q_r;

`ifdef WTS_RAM_ARBITER_ROUND_ROBIN_EN
   logic rr_wav_next;

   // Pointer only moves on contended grants; it names who wins the next tie.
   always_ff @(posedge clk) begin
      if (reset)
         rr_wav_next <= 1'b1;
      else if (cpu_elig && wav_elig)
         rr_wav_next <= (grant == OWN_CPU);
   end

   assign wav_first = rr_wav_next;
`else
   assign wav_first = 1'b1;
`endif

   assign cpu_elig = bus.cpu_req && !busy_cpu;
   assign wav_elig = bus.wav_req && !busy_wav;

   always_comb begin
      grant = OWN_NONE;
      if (wav_elig && (!cpu_elig || wav_first))
         grant = OWN_WAV;
      else if (cpu_elig)
         grant = OWN_CPU;
   end

   assign grant_a   = (grant == OWN_WAV) ? bus.wav_a : bus.cpu_a;
   assign grant_we  = (grant == OWN_CPU) && bus.cpu_we;
   assign grant_oor = int'(grant_a) >= RAM_WORDS;

   // Issue stage: RAM port plus the owner of the access presented this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         sram_we_p0 <= 1'b0;
         sram_a_p0  <= '0;
         sram_d_p0  <= '0;
         iss_own_p0 <= OWN_NONE;
         iss_wr_p0  <= 1'b0;
         iss_oor_p0 <= 1'b0;
      end else begin
         sram_we_p0 <= grant_we && !grant_oor;
         sram_a_p0  <= (grant != OWN_NONE) ? grant_a : '0;
         sram_d_p0  <= (grant_we && !grant_oor) ? bus.cpu_d : '0;
         iss_own_p0 <= grant;
         iss_wr_p0  <= grant_we;
         iss_oor_p0 <= grant_oor;
      end
   end

   // Busy stays set through the ack cycle so a req still high there is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_cpu <= 1'b0;
         busy_wav <= 1'b0;
      end else begin
         if (grant == OWN_CPU)
            busy_cpu <= 1'b1;
         else if (cpu_ack_r)
            busy_cpu <= 1'b0;
         if (grant == OWN_WAV)
            busy_wav <= 1'b1;
         else if (wav_ack_r)
            busy_wav <= 1'b0;
      end
   end

   assign tag_own = iss_wr_p0 ? OWN_NONE : iss_own_p0;

   wts_ram_arb_retire #(
      .STAGES (READ_LATENCY)
   ) u_retire (
      .clk     (clk),
      .reset   (reset),
      .tag_own (tag_own),
      .tag_oor (iss_oor_p0),
      .cap_own (cap_own),
      .cap_oor (cap_oor)
   );

   // Return stage: capture sram_q for the retiring read and pulse the owner's ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_ack_r <= 1'b0;
         wav_ack_r <= 1'b0;
         cpu_q_r   <= '0;
         wav_q_r   <= '0;
      end else begin
         cpu_ack_r <= ((iss_own_p0 == OWN_CPU) && iss_wr_p0) || (cap_own == OWN_CPU);
         wav_ack_r <= (cap_own == OWN_WAV);
         if (cap_own == OWN_CPU)
            cpu_q_r <= cap_oor ? WTS_OOR_DATA : bus.sram_q;
         if (cap_own == OWN_WAV)
            wav_q_r <= cap_oor ? WTS_OOR_DATA : bus.sram_q;
      end
   end

   assign bus.sram_we = sram_we_p0;
   assign bus.sram_a  = sram_a_p0;
   assign bus.sram_d  = sram_d_p0;
   assign bus.cpu_ack = cpu_ack_r;
   assign bus.cpu_q   = cpu_q_r;
   assign bus.wav_ack = wav_ack_r;
   assign bus.wav_q   = wav_q_r;

endmodule

// File: tb/tb_wts_ram_arbiter.sv
// Self-checking bench for wts_ram_arbiter with a behavioural RAM and requesters.
// Honours WTS_RAM_ARBITER_ROUND_ROBIN_EN for the contention expectations.
module tb_wts_ram_arbiter;
   import wts_ram_arb_pkg::*;

   localparam int RAM_WORDS    = 384;
   localparam int READ_LATENCY = 2;
   localparam int WR_LAT       = 2;
   localparam int RD_LAT       = 2 + READ_LATENCY;
`ifdef WTS_RAM_ARBITER_ROUND_ROBIN_EN
   localparam int WAV_LAT_MAX  = RD_LAT + 1;
`else
   localparam int WAV_LAT_MAX  = RD_LAT;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   wts_ram_arbiter_if bus ();

   wts_ram_arbiter #(
      .RAM_WORDS    (RAM_WORDS),
      .READ_LATENCY (READ_LATENCY)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with READ_LATENCY cycles of read delay.
   logic [7:0] ram     [512];
   logic [7:0] rd_pipe [READ_LATENCY];
   always @(posedge clk) begin
      if (bus.sram_we) ram[bus.sram_a] <= bus.sram_d;
      rd_pipe[0] <= ram[bus.sram_a];
      for (int k = 1; k < READ_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bus.sram_q = rd_pipe[READ_LATENCY-1];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cpu_ack_cnt = 0, wav_ack_cnt = 0, we_cnt = 0;
   int cpu_done = 0, wav_done = 0;
   logic       cur_wr_vld = 1'b0;
   logic [8:0] cur_wr_a = '0;
   logic [7:0] cur_wr_d = '0;
   logic [7:0] ref_mem [512];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_cpu_ack"}, int'(bus.cpu_ack), 0);
      chk({tag, "_cpu_q"},   int'(bus.cpu_q),   0);
      chk({tag, "_wav_ack"}, int'(bus.wav_ack), 0);
      chk({tag, "_wav_q"},   int'(bus.wav_q),   0);
      chk({tag, "_sram_we"}, int'(bus.sram_we), 0);
      chk({tag, "_sram_a"},  int'(bus.sram_a),  0);
      chk({tag, "_sram_d"},  int'(bus.sram_d),  0);
   endtask

   // CPU requester: holds req until ack (bounded), lat = -1 on timeout.
   task automatic cpu_access(input logic we, input logic [8:0] a, input logic [7:0] d,
                             output logic [7:0] q, output int lat);
      int  start;
      bit  got;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_a = a; bus.cpu_d = d;
      cur_wr_vld = we; cur_wr_a = a; cur_wr_d = d;
      start = cyc; got = 1'b0; lat = -1; q = '0;
      for (int i = 0; i < 16 && !got; i++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin
            got = 1'b1; lat = cyc - start; q = bus.cpu_q;
         end
      end
      bus.cpu_req = 1'b0; cur_wr_vld = 1'b0;
      cpu_done++;
   endtask

   task automatic wav_access(input logic [8:0] a, output logic [7:0] q, output int lat);
      int  start;
      bit  got;
      @(negedge clk);
      bus.wav_req = 1'b1; bus.wav_a = a;
      start = cyc; got = 1'b0; lat = -1; q = '0;
      for (int i = 0; i < 16 && !got; i++) begin
         @(negedge clk);
         if (bus.wav_ack) begin
            got = 1'b1; lat = cyc - start; q = bus.wav_q;
         end
      end
      bus.wav_req = 1'b0;
      wav_done++;
   endtask

   // Ack counting and write-source checking on every cycle.
   initial forever begin
      @(negedge clk);
      if (bus.cpu_ack) cpu_ack_cnt++;
      if (bus.wav_ack) wav_ack_cnt++;
      if (bus.sram_we) begin
         we_cnt++;
         chk("sram_we_owner", int'(cur_wr_vld), 1);
         chk("sram_we_addr", int'(bus.sram_a), int'(cur_wr_a));
         chk("sram_we_data", int'(bus.sram_d), int'(cur_wr_d));
      end
   end

   typedef struct {
      logic       we;
      logic [8:0] a;
      logic [7:0] d;
      int         exp_q;
      int         exp_lat;
   } vec_t;

   vec_t vecs [$];

   initial begin
      logic [7:0] q, q2;
      int lat, lat2, w0;

      vecs.push_back('{1'b1, 9'd0,   8'h07, -1,   WR_LAT});
      vecs.push_back('{1'b0, 9'd0,   8'h00, 7,    RD_LAT});
      vecs.push_back('{1'b1, 9'd383, 8'hA5, -1,   WR_LAT});
      vecs.push_back('{1'b0, 9'd383, 8'h00, 165,  RD_LAT});
      vecs.push_back('{1'b1, 9'd400, 8'h55, -1,   WR_LAT});
      vecs.push_back('{1'b0, 9'd400, 8'h00, 255,  RD_LAT});
      vecs.push_back('{1'b1, 9'd384, 8'h12, -1,   WR_LAT});
      vecs.push_back('{1'b0, 9'd384, 8'h00, 255,  RD_LAT});
      vecs.push_back('{1'b1, 9'd511, 8'h3C, -1,   WR_LAT});
      vecs.push_back('{1'b0, 9'd511, 8'h00, 255,  RD_LAT});
      vecs.push_back('{1'b1, 9'd1,   8'hC3, -1,   WR_LAT});
      vecs.push_back('{1'b0, 9'd0,   8'h00, 7,    RD_LAT});
      vecs.push_back('{1'b0, 9'd1,   8'h00, 195,  RD_LAT});

      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = '0; bus.cpu_d = '0;
      bus.wav_req = 1'b0; bus.wav_a = '0;
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      reset = 1'b0;

      foreach (vecs[i]) begin
         w0 = we_cnt;
         cpu_access(vecs[i].we, vecs[i].a, vecs[i].d, q, lat);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         if (vecs[i].exp_q >= 0) chk($sformatf("vec%0d_q", i), int'(q), vecs[i].exp_q);
         chk($sformatf("vec%0d_we_pulses", i), we_cnt - w0,
             (vecs[i].we && int'(vecs[i].a) < RAM_WORDS) ? 1 : 0);
      end

      for (int a = 0; a < RAM_WORDS; a++) begin
         w0 = we_cnt;
         ref_mem[a] = 8'((a + 100) % 256);
         cpu_access(1'b1, 9'(a), ref_mem[a], q, lat);
         chk($sformatf("sweep_wr%0d_lat", a), lat, WR_LAT);
         chk($sformatf("sweep_wr%0d_we_pulses", a), we_cnt - w0, 1);
      end
      for (int a = 0; a < RAM_WORDS; a++) begin
         cpu_access(1'b0, 9'(a), 8'h00, q, lat);
         chk($sformatf("sweep_rd%0d_lat", a), lat, RD_LAT);
         chk($sformatf("sweep_rd%0d_q", a), int'(q), (a + 100) % 256);
      end

      for (int n = 0; n < 2; n++) begin
         fork
            cpu_access(1'b0, 9'd5, 8'h00, q, lat);
            wav_access(9'd10, q2, lat2);
         join
         chk($sformatf("contend%0d_cpu_q", n), int'(q), 105);
         chk($sformatf("contend%0d_wav_q", n), int'(q2), 110);
`ifdef WTS_RAM_ARBITER_ROUND_ROBIN_EN
         chk($sformatf("contend%0d_cpu_lat", n), lat,  (n == 0) ? RD_LAT + 1 : RD_LAT);
         chk($sformatf("contend%0d_wav_lat", n), lat2, (n == 0) ? RD_LAT : RD_LAT + 1);
`else
         chk($sformatf("contend%0d_cpu_lat", n), lat,  RD_LAT + 1);
         chk($sformatf("contend%0d_wav_lat", n), lat2, RD_LAT);
`endif
      end

      fork
         begin
            for (int n = 0; n < 60; n++) begin
               logic       we;
               logic [8:0] a;
               logic [7:0] d, rq;
               int         rl, wc;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               we = 1'($urandom_range(0, 1));
               a  = ($urandom_range(0, 7) == 0) ? 9'(384 + $urandom_range(0, 127))
                                                : 9'(192 + $urandom_range(0, 191));
               d  = 8'($urandom);
               wc = we_cnt;
               cpu_access(we, a, d, rq, rl);
               if (we) begin
                  chk_rng($sformatf("rnd_cpu_wr%0d_lat", n), rl, WR_LAT, WR_LAT + 1);
                  chk($sformatf("rnd_cpu_wr%0d_we_pulses", n), we_cnt - wc,
                      (int'(a) < RAM_WORDS) ? 1 : 0);
                  if (int'(a) < RAM_WORDS) ref_mem[a] = d;
               end else begin
                  chk_rng($sformatf("rnd_cpu_rd%0d_lat", n), rl, RD_LAT, RD_LAT + 1);
                  chk($sformatf("rnd_cpu_rd%0d_q", n), int'(rq),
                      (int'(a) < RAM_WORDS) ? int'(ref_mem[a]) : 255);
               end
            end
         end
         begin
            for (int n = 0; n < 80; n++) begin
               logic [8:0] a;
               logic [7:0] rq;
               int         rl;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               a = ($urandom_range(0, 7) == 0) ? 9'(384 + $urandom_range(0, 127))
                                               : 9'($urandom_range(0, 191));
               wav_access(a, rq, rl);
               chk_rng($sformatf("rnd_wav%0d_lat", n), rl, RD_LAT, WAV_LAT_MAX);
               chk($sformatf("rnd_wav%0d_q", n), int'(rq),
                   (int'(a) < RAM_WORDS) ? int'(ref_mem[a]) : 255);
            end
         end
      join

      // Reset one cycle after a wave read is presented to the RAM.
      @(negedge clk);
      bus.wav_req = 1'b1; bus.wav_a = 9'd10;
      @(negedge clk);
      chk("rst_issue_addr", int'(bus.sram_a), 10);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus.wav_req = 1'b0;
      chk_outputs_zero("mid_reset");
      reset = 1'b0;
      w0 = wav_ack_cnt;
      repeat (6) @(negedge clk);
      chk("rst_no_wav_ack", wav_ack_cnt - w0, 0);

      cpu_access(1'b0, 9'd5, 8'h00, q, lat);
      chk("post_rst_cpu_lat", lat, RD_LAT);
      chk("post_rst_cpu_q", int'(q), 105);
      wav_access(9'd10, q2, lat2);
      chk("post_rst_wav_lat", lat2, RD_LAT);
      chk("post_rst_wav_q", int'(q2), 110);

      repeat (4) @(negedge clk);
      chk("cpu_ack_total", cpu_ack_cnt, cpu_done);
      chk("wav_ack_total", wav_ack_cnt, wav_done);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
